// File: rtl/usb_fs_tx_phy_if.sv
// Byte-stream handshake between a packet producer and the full-speed USB line transmitter.
interface usb_fs_tx_phy_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_last, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_last, input  tx_valid, output tx_ready);
endinterface

// File: rtl/usb_fs_tx_phy.sv
// Full-speed USB line transmitter: SYNC, bit stuffing, NRZI and EOP onto D+/D- drive levels.
// One byte of holding register lets the producer refill while the shifter is busy.
module usb_fs_tx_phy #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STUFF_LEN    = 6
) (
    input  logic           clk_48mhz,
    input  logic           reset,
    usb_fs_tx_phy_if.slave tx,
    output logic           usb_p_tx,
    output logic           usb_n_tx,
    output logic           usb_tx_en,
    output logic           busy,
    output logic           underrun
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned OW = $clog2(STUFF_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    sh_q;
    logic [3:0]    rem_q;
    logic [OW-1:0] ones_q;
    logic          cur_last_q;
    logic [7:0]    hold_q;
    logic          hold_full_q, hold_last_q, last_acc_q;
    logic          line_j_q, eop_cnt_q;
    logic          ready_q, p_q, n_q, en_q, busy_q, underrun_q;

    logic       accept_c, bound_c, stuff_c, byte_end_c, need_byte_c;
    logic       load_hold_c, bypass_c, under_c, eop_go_c, bit_c, new_j_c;
    logic [7:0] next_byte_c;
    logic       next_last_c, hold_full_d, last_acc_d;

    // Bit-boundary decisions; a byte may bypass the holding register if it arrives exactly at the boundary.
    always_comb begin
        accept_c    = tx.tx_valid && ready_q;
        bound_c     = (state_q != S_IDLE) && (cnt_q == CW'(CLKS_PER_BIT - 1));
        stuff_c     = (ones_q == OW'(STUFF_LEN));
        byte_end_c  = bound_c && (state_q == S_SYNC || state_q == S_DATA) && !stuff_c && (rem_q == 4'd0);
        need_byte_c = byte_end_c && (state_q == S_SYNC || !cur_last_q);
        load_hold_c = need_byte_c && hold_full_q;
        bypass_c    = need_byte_c && !hold_full_q && accept_c;
        under_c     = need_byte_c && !hold_full_q && !accept_c;
        eop_go_c    = byte_end_c && (state_q == S_DATA) && (cur_last_q || under_c);
        next_byte_c = load_hold_c ? hold_q : tx.tx_data;
        next_last_c = load_hold_c ? hold_last_q : tx.tx_last;
        hold_full_d = (hold_full_q && !load_hold_c) || (accept_c && !bypass_c);
        last_acc_d  = last_acc_q || (accept_c && tx.tx_last);
        bit_c       = 1'b0;
        if (!stuff_c) begin
            bit_c = (rem_q != 4'd0) ? sh_q[0] : next_byte_c[0];
        end
        new_j_c = bit_c ? line_j_q : !line_j_q;
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            rem_q       <= '0;
            ones_q      <= '0;
            cur_last_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            last_acc_q  <= 1'b0;
            line_j_q    <= 1'b1;
            eop_cnt_q   <= 1'b0;
            ready_q     <= 1'b0;
            p_q         <= 1'b1;
            n_q         <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q  <= 1'b0;
            cnt_q       <= (state_q == S_IDLE) ? '0 : cnt_q + CW'(1);
            hold_full_q <= hold_full_d;
            last_acc_q  <= last_acc_d;
            if (accept_c && !bypass_c) begin
                hold_q      <= tx.tx_data;
                hold_last_q <= tx.tx_last;
            end
            case (state_q)
                S_IDLE: begin
                    last_acc_q <= accept_c && tx.tx_last;
                    ready_q    <= !accept_c;
                    if (accept_c) begin
                        state_q  <= S_SYNC;
                        en_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        line_j_q <= 1'b0;
                        p_q      <= 1'b0;
                        n_q      <= 1'b1;
                        sh_q     <= 8'h40;
                        rem_q    <= 4'd7;
                        ones_q   <= '0;
                    end
                end
                S_SYNC, S_DATA: begin
                    ready_q <= (state_q == S_DATA || byte_end_c) && !hold_full_d && !last_acc_d;
                    if (bound_c) begin
                        if (eop_go_c) begin
                            state_q    <= S_EOP_SE0;
                            p_q        <= 1'b0;
                            n_q        <= 1'b0;
                            eop_cnt_q  <= 1'b0;
                            ready_q    <= 1'b0;
                            underrun_q <= under_c;
                        end else begin
                            line_j_q <= new_j_c;
                            p_q      <= new_j_c;
                            n_q      <= !new_j_c;
                            ones_q   <= (stuff_c || !bit_c) ? '0 : ones_q + OW'(1);
                            // A stuffed bit leaves the shifter paused.
                            if (!stuff_c) begin
                                if (rem_q != 4'd0) begin
                                    sh_q  <= sh_q >> 1;
                                    rem_q <= rem_q - 4'd1;
                                end else begin
                                    sh_q       <= next_byte_c >> 1;
                                    rem_q      <= 4'd7;
                                    cur_last_q <= next_last_c;
                                    state_q    <= S_DATA;
                                end
                            end
                        end
                    end
                end
                S_EOP_SE0: begin
                    ready_q <= 1'b0;
                    if (bound_c) begin
                        if (eop_cnt_q) begin
                            state_q  <= S_EOP_J;
                            line_j_q <= 1'b1;
                            p_q      <= 1'b1;
                            n_q      <= 1'b0;
                        end else begin
                            eop_cnt_q <= 1'b1;
                        end
                    end
                end
                S_EOP_J: begin
                    ready_q <= 1'b0;
                    if (bound_c) begin
                        state_q <= S_IDLE;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx.tx_ready = ready_q;
    assign usb_p_tx    = p_q;
    assign usb_n_tx    = n_q;
    assign usb_tx_en   = en_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;
endmodule

// File: tb/tb_usb_fs_tx_phy.sv
// Directed bench for usb_fs_tx_phy: records line symbols mid-bit, decodes NRZI/stuffing and checks timing.
module tb_usb_fs_tx_phy;
    localparam int unsigned STUFF = 6;

    logic clk = 1'b0;
    logic reset;
    logic usb_p_tx, usb_n_tx, usb_tx_en, busy, underrun;

    usb_fs_tx_phy_if ifc ();

    usb_fs_tx_phy dut (
        .clk_48mhz (clk),
        .reset     (reset),
        .tx        (ifc.slave),
        .usb_p_tx  (usb_p_tx),
        .usb_n_tx  (usb_n_tx),
        .usb_tx_en (usb_tx_en),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Symbol code: 0 = SE0, 1 = J, 2 = K.
    logic [1:0] syms[$];
    logic [7:0] dec_q[$];
    int en_cyc = 0, ph = 0, under_cnt = 0, acc_cnt = 0;

    always @(negedge clk) begin
        if (usb_tx_en) begin
            if (ph % 4 == 1) syms.push_back({usb_n_tx, usb_p_tx});
            ph     = ph + 1;
            en_cyc = en_cyc + 1;
        end else begin
            ph = 0;
        end
    end

    always @(posedge clk) begin
        if (ifc.tx_valid && ifc.tx_ready) acc_cnt = acc_cnt + 1;
        if (underrun) under_cnt = under_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input int n, input bit trunc);
        logic [7:0] bs [3];
        int t;
        bs = '{b0, b1, b2};
        for (int i = 0; i < n; i++) begin
            ifc.tx_data  = bs[i];
            ifc.tx_last  = (i == n - 1) && !trunc;
            ifc.tx_valid = 1'b1;
            t = 0;
            while (!ifc.tx_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            check("accept_wait", 32'(t < 400), 32'd1);
            @(negedge clk);
        end
        ifc.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (usb_tx_en && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("end_timeout", 32'(t < 2000), 32'd1);
        @(negedge clk);
    endtask

    // Independent receive-side decode: NRZI, destuff, strip SYNC.
    task automatic decode(input int base);
        logic [1:0] prev;
        logic [7:0] cur, sync;
        logic       b;
        int ones, nb, serr;
        dec_q.delete();
        prev = 2'd1; ones = 0; nb = 0; serr = 0; cur = '0; sync = '0;
        for (int i = base; i < syms.size(); i++) begin
            if (syms[i] == 2'd0) break;
            b    = (syms[i] == prev);
            prev = syms[i];
            if (ones == STUFF) begin
                if (b) serr++;
                ones = 0;
            end else begin
                ones = b ? ones + 1 : 0;
                cur  = {b, cur[7:1]};
                nb++;
                if (nb % 8 == 0) begin
                    if (nb == 8) sync = cur;
                    else dec_q.push_back(cur);
                end
            end
        end
        check("sync_byte", 32'(sync), 32'h80);
        check("stuff_rule", 32'(serr), 32'd0);
        check("whole_bytes", 32'(nb % 8), 32'd0);
    endtask

    int base, en0, un0, acc0, tog;
    int exp_a5 [19] = '{2,1,2,1,2,1,2,2, 2,1,1,2,1,1,2,2, 0,0,1};

    initial begin
        reset = 1'b1;
        ifc.tx_data = '0; ifc.tx_last = 1'b0; ifc.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_p", 32'(usb_p_tx), 32'd1);
        check("rst_n", 32'(usb_n_tx), 32'd0);
        check("rst_en", 32'(usb_tx_en), 32'd0);
        check("rst_ready", 32'(ifc.tx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 0xA5 single byte
        base = syms.size(); en0 = en_cyc; un0 = under_cnt;
        send(8'hA5, 8'h00, 8'h00, 1, 1'b0);
        wait_idle();
        check("a5_en_cycles", 32'(en_cyc - en0), 32'd76);
        check("a5_underrun", 32'(under_cnt - un0), 32'd0);
        check("a5_nsyms", 32'(syms.size() - base), 32'd19);
        for (int i = 0; i < 19; i++) check($sformatf("a5_sym%0d", i), 32'(syms[base + i]), 32'(exp_a5[i]));
        decode(base);
        check("a5_nbytes", 32'(dec_q.size()), 32'd1);
        if (dec_q.size() > 0) check("a5_byte", 32'(dec_q[0]), 32'hA5);
        check("a5_ready_idle", 32'(ifc.tx_ready), 32'd1);
        check("a5_busy_idle", 32'(busy), 32'd0);

        // 0xFF forces one stuffed bit
        base = syms.size(); en0 = en_cyc;
        send(8'hFF, 8'h00, 8'h00, 1, 1'b0);
        wait_idle();
        check("ff_en_cycles", 32'(en_cyc - en0), 32'd80);
        tog = 0;
        for (int i = 8; i <= 16; i++) if (syms[base + i] != syms[base + i - 1]) tog++;
        check("ff_data_toggles", 32'(tog), 32'd1);
        decode(base);
        check("ff_nbytes", 32'(dec_q.size()), 32'd1);
        if (dec_q.size() > 0) check("ff_byte", 32'(dec_q[0]), 32'hFF);

        // Three bytes, valid held high
        base = syms.size(); en0 = en_cyc; acc0 = acc_cnt; un0 = under_cnt;
        send(8'h01, 8'h02, 8'h03, 3, 1'b0);
        wait_idle();
        check("m3_en_cycles", 32'(en_cyc - en0), 32'd140);
        check("m3_accepts", 32'(acc_cnt - acc0), 32'd3);
        check("m3_underrun", 32'(under_cnt - un0), 32'd0);
        decode(base);
        check("m3_nbytes", 32'(dec_q.size()), 32'd3);
        if (dec_q.size() == 3) begin
            check("m3_byte0", 32'(dec_q[0]), 32'h01);
            check("m3_byte1", 32'(dec_q[1]), 32'h02);
            check("m3_byte2", 32'(dec_q[2]), 32'h03);
        end

        // Underrun after a non-last byte
        base = syms.size(); en0 = en_cyc; un0 = under_cnt;
        send(8'h12, 8'h00, 8'h00, 1, 1'b1);
        wait_idle();
        check("ur_pulses", 32'(under_cnt - un0), 32'd1);
        check("ur_en_cycles", 32'(en_cyc - en0), 32'd76);
        decode(base);
        check("ur_nbytes", 32'(dec_q.size()), 32'd1);
        if (dec_q.size() > 0) check("ur_byte", 32'(dec_q[0]), 32'h12);

        // Reset 20 cycles into the data field
        send(8'h00, 8'h00, 8'h00, 1, 1'b0);
        repeat (52) @(negedge clk);
        check("ab_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("ab_en", 32'(usb_tx_en), 32'd0);
        check("ab_p", 32'(usb_p_tx), 32'd1);
        check("ab_n", 32'(usb_n_tx), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        base = syms.size(); en0 = en_cyc;
        send(8'hC3, 8'h00, 8'h00, 1, 1'b0);
        wait_idle();
        check("ab_new_en_cycles", 32'(en_cyc - en0), 32'd76);
        decode(base);
        check("ab_new_nbytes", 32'(dec_q.size()), 32'd1);
        if (dec_q.size() > 0) check("ab_new_byte", 32'(dec_q[0]), 32'hC3);

        // tx_valid held across reset release
        reset = 1'b1;
        ifc.tx_data = 8'h3C; ifc.tx_last = 1'b1; ifc.tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rv_ready_in_reset", 32'(ifc.tx_ready), 32'd0);
        acc0 = acc_cnt; en0 = en_cyc; base = syms.size();
        reset = 1'b0;
        @(negedge clk);
        check("rv_ready_c1", 32'(ifc.tx_ready), 32'd1);
        check("rv_en_c1", 32'(usb_tx_en), 32'd0);
        check("rv_acc_c1", 32'(acc_cnt - acc0), 32'd0);
        @(negedge clk);
        check("rv_en_c2", 32'(usb_tx_en), 32'd1);
        check("rv_busy_c2", 32'(busy), 32'd1);
        check("rv_ready_c2", 32'(ifc.tx_ready), 32'd0);
        check("rv_sync_k", 32'({usb_n_tx, usb_p_tx}), 32'd2);
        ifc.tx_valid = 1'b0;
        wait_idle();
        check("rv_accepts", 32'(acc_cnt - acc0), 32'd1);
        check("rv_en_cycles", 32'(en_cyc - en0), 32'd76);
        decode(base);
        check("rv_nbytes", 32'(dec_q.size()), 32'd1);
        if (dec_q.size() > 0) check("rv_byte", 32'(dec_q[0]), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
